// File: rtl/counter_pkg.sv
// Shared counter types and the terminal-count helper.
// Used by the modulo counter and later cascade blocks.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // True when q sits at the limit it is heading toward:
  // mod-1 when counting up, 0 when counting down.
  function automatic logic is_terminal(
    input logic [15:0] q,
    input dir_e        dir,
    input logic [16:0] mod
  );
    logic [16:0] top;
    top = mod - 17'd1;
    if (dir == DIR_UP) return {1'b0, q} == top;
    return q == 16'd0;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Next-state logic for the modulo counter.
// in: q, dir, en, load, d   out: q_next, wrap_next
module counter_next
  import counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic [N-1:0] q,
  input  logic         dir,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q_next,
  output logic         wrap_next
);

  localparam logic [N-1:0] MAXV = N'(MODULUS - 1);

  logic at_lim;
  logic step;
  logic lim;

  assign at_lim = is_terminal(16'(q), dir_e'(dir), 17'(MODULUS));
  assign step   = !load && en && !at_lim;
  assign lim    = !load && en && at_lim;

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    unique case (1'b1)
      load: begin
        q_next = (d > MAXV) ? MAXV : d;
      end
      lim: begin
        if (SATURATE == 0) begin
          q_next    = dir ? '0 : MAXV;
          wrap_next = 1'b1;
        end
      end
      step: begin
        q_next = dir ? q + N'(1) : q - N'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with load, enable, wrap/saturate.
// in: clk, reset(active-low sync), en, dir, load, d  out: q, tc, wrap
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap
);

  if (MODULUS > 2**N || MODULUS < 2) begin : g_bad_mod
    $error("counter_updown_mod: MODULUS out of range");
  end

  logic [N-1:0] q_next;
  logic         wrap_next;

  counter_next #(
    .N        (N),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .q         (q),
    .dir       (dir),
    .en        (en),
    .load      (load),
    .d         (d),
    .q_next    (q_next),
    .wrap_next (wrap_next)
  );

  // tc ignores load and SATURATE so cascades see the limit directly.
  assign tc = en && is_terminal(16'(q), dir_e'(dir), 17'(MODULUS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule
